// File: rtl/pcs_pkg.sv
// Shared 10GBASE-R PCS constants for the scrambler/descrambler pair.
// Polynomial G(x) = 1 + x^39 + x^58. Taps index the 58-bit state where
// bit 0 holds the most recently shifted-in line bit.
package pcs_pkg;

  localparam int unsigned LFSR_WIDTH     = 58;
  localparam int unsigned TAP_A          = 38;
  localparam int unsigned TAP_B          = 57;
  localparam int unsigned SYNC_BITS      = 58;
  localparam int unsigned SYNC_CNT_WIDTH = 7;

  typedef logic [LFSR_WIDTH-1:0] lfsr_t;

  localparam lfsr_t LFSR_INIT = '1;

endpackage

// File: rtl/pcs_skid_buffer.sv
// Output register plus one skid register with a registered upstream ready.
// Ports:
//   i_clk, i_reset_n       clock, async active-low reset
//   i_data/i_valid/o_ready upstream handshake (o_ready == NOT skid full)
//   o_data/o_valid/i_ready downstream handshake, o_data held while stalled
module pcs_skid_buffer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready
);

  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] skid_d;
  logic             skid_full_q;
  logic             skid_full_d;
  logic [WIDTH-1:0] out_d;
  logic             out_valid_d;
  logic             accept;
  logic             out_free;

  assign accept   = i_valid & o_ready;
  assign out_free = ~o_valid | i_ready;

  // Next-state: the skid word always drains first so order is preserved.
  always_comb begin
    skid_d      = skid_q;
    skid_full_d = skid_full_q;
    out_d       = o_data;
    out_valid_d = o_valid;
    if (out_free) begin
      if (skid_full_q) begin
        out_d       = skid_q;
        out_valid_d = 1'b1;
        skid_full_d = 1'b0;
      end else if (accept) begin
        out_d       = i_data;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d      = i_data;
      skid_full_d = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      skid_q      <= '0;
      skid_full_q <= 1'b0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_ready     <= 1'b1;
    end else begin
      skid_q      <= skid_d;
      skid_full_q <= skid_full_d;
      o_data      <= out_d;
      o_valid     <= out_valid_d;
      o_ready     <= ~skid_full_d;
    end
  end

endmodule

// File: rtl/descrambler.sv
// 10GBASE-R receive self-synchronizing descrambler, G(x) = 1 + x^39 + x^58.
// Ports:
//   i_clk, i_reset_n                       clock, async active-low reset
//   i_rx_data/i_rx_data_valid/o_rx_trdy    scrambled words from block sync
//   i_block_lock                           block-sync lock status
//   o_tx_data/o_tx_data_valid/i_tx_trdy    descrambled words to the decoder
//   o_sync_ok                              LFSR filled with >= 58 bits since lock
//   i_bypass                               only with DESCRAMBLER_BYPASS_EN:
//                                          pass words unmodified
// Optional feature macro: DESCRAMBLER_BYPASS_EN.
module descrambler
  import pcs_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic                  i_rx_data_valid,
  output logic                  o_rx_trdy,
  input  logic                  i_block_lock,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic                  o_tx_data_valid,
  input  logic                  i_tx_trdy,
  output logic                  o_sync_ok
`ifdef DESCRAMBLER_BYPASS_EN
  ,
  input  logic                  i_bypass
`endif
);

  localparam int unsigned SUM_WIDTH = SYNC_CNT_WIDTH + 1;
  localparam logic [SUM_WIDTH-1:0] SYNC_STEP = SUM_WIDTH'(DATA_WIDTH);
  localparam logic [SUM_WIDTH-1:0] SYNC_MAX  = SUM_WIDTH'(SYNC_BITS);

  logic                      accept;
  lfsr_t                     lfsr_q;
  lfsr_t                     lfsr_d;
  lfsr_t                     lfsr_walk;
  logic [DATA_WIDTH-1:0]     desc_data;
  logic [DATA_WIDTH-1:0]     payload;
  logic [SYNC_CNT_WIDTH-1:0] sync_cnt_q;
  logic [SYNC_CNT_WIDTH-1:0] sync_cnt_d;
  logic [SUM_WIDTH-1:0]      sync_sum;
  logic                      sync_ok_d;

  assign accept = i_rx_data_valid & o_rx_trdy;

  // Serial descramble unrolled over the word; the state shifts in the
  // scrambled line bit, which is what makes the receiver self-synchronizing.
  always_comb begin
    lfsr_walk = lfsr_q;
    desc_data = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      desc_data[i] = i_rx_data[i] ^ lfsr_walk[TAP_A] ^ lfsr_walk[TAP_B];
      lfsr_walk    = {lfsr_walk[LFSR_WIDTH-2:0], i_rx_data[i]};
    end
    lfsr_d = accept ? lfsr_walk : lfsr_q;
  end

  // Word handed to the pipeline.
  always_comb begin
`ifdef DESCRAMBLER_BYPASS_EN
    payload = i_bypass ? i_rx_data : desc_data;
`else
    payload = desc_data;
`endif
  end

  // Sync qualification: loss of lock clears, otherwise count accepted bits.
  always_comb begin
    sync_sum   = {1'b0, sync_cnt_q} + SYNC_STEP;
    sync_cnt_d = sync_cnt_q;
    if (!i_block_lock) begin
      sync_cnt_d = '0;
    end else if (accept) begin
      sync_cnt_d = (sync_sum >= SYNC_MAX) ? SYNC_CNT_WIDTH'(SYNC_BITS)
                                          : SYNC_CNT_WIDTH'(sync_sum);
    end
    sync_ok_d = (sync_cnt_d == SYNC_CNT_WIDTH'(SYNC_BITS));
  end

  // State registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      lfsr_q     <= LFSR_INIT;
      sync_cnt_q <= '0;
      o_sync_ok  <= 1'b0;
    end else begin
      lfsr_q     <= lfsr_d;
      sync_cnt_q <= sync_cnt_d;
      o_sync_ok  <= sync_ok_d;
    end
  end

  pcs_skid_buffer #(
    .WIDTH (DATA_WIDTH)
  ) u_skid (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_data    (payload),
    .i_valid   (i_rx_data_valid),
    .o_ready   (o_rx_trdy),
    .o_data    (o_tx_data),
    .o_valid   (o_tx_data_valid),
    .i_ready   (i_tx_trdy)
  );

endmodule

// File: tb/tb_descrambler.sv
// Self-checking bench for descrambler (DATA_WIDTH = 32).
// Reference: line-bit history model, d[n] = r[n] ^ r[n-39] ^ r[n-58], with
// bits before reset taken as ones; TX scrambler modelled the same way.
module tb_descrambler;

  localparam int unsigned DW = 32;

  logic          i_clk;
  logic          i_reset_n;
  logic [DW-1:0] i_rx_data;
  logic          i_rx_data_valid;
  logic          o_rx_trdy;
  logic          i_block_lock;
  logic [DW-1:0] o_tx_data;
  logic          o_tx_data_valid;
  logic          i_tx_trdy;
  logic          o_sync_ok;
`ifdef DESCRAMBLER_BYPASS_EN
  logic          i_bypass;
`endif

  descrambler #(.DATA_WIDTH(DW)) dut (
    .i_clk           (i_clk),
    .i_reset_n       (i_reset_n),
    .i_rx_data       (i_rx_data),
    .i_rx_data_valid (i_rx_data_valid),
    .o_rx_trdy       (o_rx_trdy),
    .i_block_lock    (i_block_lock),
    .o_tx_data       (o_tx_data),
    .o_tx_data_valid (o_tx_data_valid),
    .i_tx_trdy       (i_tx_trdy),
    .o_sync_ok       (o_sync_ok)
`ifdef DESCRAMBLER_BYPASS_EN
    ,
    .i_bypass        (i_bypass)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference models ----------------
  bit tx_hist[$];
  bit rx_hist[$];
  bit tx_init = 1'b1;

  function automatic bit tx_past(input int k);
    return (tx_hist.size() >= k) ? tx_hist[tx_hist.size() - k] : tx_init;
  endfunction

  function automatic bit rx_past(input int k);
    return (rx_hist.size() >= k) ? rx_hist[rx_hist.size() - k] : 1'b1;
  endfunction

  function automatic logic [DW-1:0] scramble(input logic [DW-1:0] p);
    logic [DW-1:0] s;
    bit b;
    s = '0;
    for (int i = 0; i < DW; i++) begin
      b    = p[i] ^ tx_past(39) ^ tx_past(58);
      s[i] = b;
      tx_hist.push_back(b);
      if (tx_hist.size() > 58) void'(tx_hist.pop_front());
    end
    return s;
  endfunction

  function automatic void tx_raw(input logic [DW-1:0] w);
    for (int i = 0; i < DW; i++) begin
      tx_hist.push_back(w[i]);
      if (tx_hist.size() > 58) void'(tx_hist.pop_front());
    end
  endfunction

  function automatic logic [DW-1:0] descramble_ref(input logic [DW-1:0] r);
    logic [DW-1:0] d;
    d = '0;
    for (int i = 0; i < DW; i++) begin
      d[i] = r[i] ^ rx_past(39) ^ rx_past(58);
      rx_hist.push_back(r[i]);
      if (rx_hist.size() > 58) void'(rx_hist.pop_front());
    end
    return d;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  typedef struct {
    logic [DW-1:0] exp;
    logic [DW-1:0] plain;
    bit            chk;
  } sb_t;

  sb_t           sb[$];
  sb_t           mon_e;
  logic [DW-1:0] cur_plain = '0;
  bit            cur_chk   = 1'b0;
  int            lock_bits = 0;
  bit            exp_ok    = 1'b0;

  always @(negedge i_clk) begin
    if (!i_reset_n) begin
      sb.delete();
      rx_hist.delete();
      lock_bits = 0;
      exp_ok    = 1'b0;
    end else begin
      check("sync_ok", 64'(o_sync_ok), 64'(exp_ok));
      if (o_tx_data_valid && i_tx_trdy) begin
        if (sb.size() == 0) begin
          check("out_unexpected", 64'(o_tx_data_valid), 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check("out_model", 64'(o_tx_data), 64'(mon_e.exp));
          if (mon_e.chk) check("out_plain", 64'(o_tx_data), 64'(mon_e.plain));
        end
      end
      if (i_rx_data_valid && o_rx_trdy) begin
        mon_e.exp = descramble_ref(i_rx_data);
`ifdef DESCRAMBLER_BYPASS_EN
        if (i_bypass) mon_e.exp = i_rx_data;
`endif
        mon_e.plain = cur_plain;
        mon_e.chk   = cur_chk;
        sb.push_back(mon_e);
        if (i_block_lock) lock_bits = (lock_bits + DW >= 58) ? 58 : lock_bits + DW;
      end
      if (!i_block_lock) lock_bits = 0;
      exp_ok = (lock_bits >= 58);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    i_reset_n       = 1'b0;
    i_rx_data_valid = 1'b0;
    i_rx_data       = '0;
    i_tx_trdy       = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_tx_valid", 64'(o_tx_data_valid), 64'd0);
    check("rst_tx_data",  64'(o_tx_data),       64'd0);
    check("rst_rx_trdy",  64'(o_rx_trdy),       64'd1);
    check("rst_sync_ok",  64'(o_sync_ok),       64'd0);
    i_reset_n = 1'b1;
    tx_hist.delete();
    tx_init = 1'b1;
  endtask

  task automatic drain();
    int cyc = 0;
    i_rx_data_valid = 1'b0;
    i_tx_trdy       = 1'b1;
    while (sb.size() != 0 && cyc < 20) begin
      @(posedge i_clk);
      #1;
      cyc++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  // Random stream; each presented word is held until accepted.
  task automatic stream(input int n, input bit counting, input int chk_from,
                        input int lock_drop_cyc, input int rdy_pct);
    int idx = 0;
    int cyc = 0;
    bit acc;
    while (idx < n && cyc < 5000) begin
      if (!i_rx_data_valid && $urandom_range(0, 3) != 0) begin
        cur_plain       = counting ? DW'(idx + 1) : DW'($urandom);
        cur_chk         = (idx >= chk_from);
        i_rx_data       = scramble(cur_plain);
        i_rx_data_valid = 1'b1;
      end
      i_tx_trdy    = ($urandom_range(0, 99) < rdy_pct);
      i_block_lock = (cyc != lock_drop_cyc);
      @(negedge i_clk);
      acc = i_rx_data_valid && o_rx_trdy;
      @(posedge i_clk);
      #1;
      cyc++;
      if (acc) begin
        i_rx_data_valid = 1'b0;
        idx++;
      end
    end
    if (idx < n) check("stream_timeout", 64'(idx), 64'(n));
    i_rx_data_valid = 1'b0;
    i_block_lock    = 1'b1;
  endtask

  task automatic send_one(input logic [DW-1:0] line_w, input logic [DW-1:0] plain);
    int cyc = 0;
    bit acc = 1'b0;
    cur_plain       = plain;
    cur_chk         = 1'b1;
    i_rx_data       = line_w;
    i_rx_data_valid = 1'b1;
    while (!acc && cyc < 100) begin
      @(negedge i_clk);
      acc = i_rx_data_valid && o_rx_trdy;
      @(posedge i_clk);
      #1;
      cyc++;
    end
    if (!acc) check("send_timeout", 64'(acc), 64'd1);
    i_rx_data_valid = 1'b0;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [DW-1:0] w0;
    logic [DW-1:0] w1;
    bit            lock;
    logic [DW-1:0] e0;
    logic [DW-1:0] e1;
    bit            e_ok;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 32'h03FFFF80, 1'b1};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1};
    vecs[2] = '{32'h12345678, 32'h00000000, 1'b1, 32'h12345678, 32'hF9D4C380, 1'b1};
    vecs[3] = '{32'h12345678, 32'h00000000, 1'b0, 32'h12345678, 32'hF9D4C380, 1'b0};

    i_reset_n       = 1'b0;
    i_rx_data       = '0;
    i_rx_data_valid = 1'b0;
    i_tx_trdy       = 1'b1;
    i_block_lock    = 1'b1;
`ifdef DESCRAMBLER_BYPASS_EN
    i_bypass        = 1'b0;
`endif

    // Two-word sequences straight after reset (LFSR all ones).
    for (int k = 0; k < 4; k++) begin
      do_reset();
      cur_chk         = 1'b0;
      i_block_lock    = vecs[k].lock;
      i_rx_data       = vecs[k].w0;
      i_rx_data_valid = 1'b1;
      @(posedge i_clk);
      #1;
      check($sformatf("tbl%0d_v0", k),  64'(o_tx_data_valid), 64'd1);
      check($sformatf("tbl%0d_d0", k),  64'(o_tx_data),       64'(vecs[k].e0));
      check($sformatf("tbl%0d_ok0", k), 64'(o_sync_ok),       64'd0);
      i_rx_data = vecs[k].w1;
      @(posedge i_clk);
      #1;
      i_rx_data_valid = 1'b0;
      check($sformatf("tbl%0d_d1", k),  64'(o_tx_data),       64'(vecs[k].e1));
      check($sformatf("tbl%0d_ok1", k), 64'(o_sync_ok),       64'(vecs[k].e_ok));
      i_block_lock = 1'b1;
      drain();
    end

    // Loopback of 1..256 from word 0.
    do_reset();
    stream(256, 1'b1, 0, -1, 70);
    drain();

    // Backpressure: output stalled 5 cycles with input valid held.
    do_reset();
    i_block_lock    = 1'b1;
    i_tx_trdy       = 1'b0;
    cur_plain       = 32'd1;
    cur_chk         = 1'b1;
    i_rx_data       = scramble(32'd1);
    i_rx_data_valid = 1'b1;
    @(posedge i_clk);
    #1;
    check("bp_rdy_c1", 64'(o_rx_trdy), 64'd1);
    check("bp_data_c1", 64'(o_tx_data), 64'd1);
    cur_plain = 32'd2;
    i_rx_data = scramble(32'd2);
    for (int k = 2; k <= 5; k++) begin
      @(posedge i_clk);
      #1;
      check($sformatf("bp_rdy_c%0d", k),   64'(o_rx_trdy),       64'd0);
      check($sformatf("bp_valid_c%0d", k), 64'(o_tx_data_valid), 64'd1);
      check($sformatf("bp_data_c%0d", k),  64'(o_tx_data),       64'd1);
      if (k == 2) begin
        cur_plain = 32'd3;
        i_rx_data = scramble(32'd3);
      end
    end
    i_tx_trdy = 1'b1;
    @(posedge i_clk);
    #1;
    check("bp_rdy_back", 64'(o_rx_trdy), 64'd1);
    check("bp_data_b",   64'(o_tx_data), 64'd2);
    @(posedge i_clk);
    #1;
    i_rx_data_valid = 1'b0;
    check("bp_data_c", 64'(o_tx_data), 64'd3);
    drain();

    // Self-sync: scrambler starts from zeros, descrambler from ones.
    do_reset();
    tx_init = 1'b0;
    stream(100, 1'b0, 2, -1, 60);
    drain();

    // Lock dropped for one cycle mid-stream.
    do_reset();
    stream(60, 1'b1, 0, 30, 80);
    drain();

    // Mid-stream reset with words in flight, then clean loopback again.
    do_reset();
    stream(20, 1'b1, 0, -1, 50);
    i_tx_trdy       = 1'b0;
    i_rx_data       = scramble(32'hDEAD0000);
    i_rx_data_valid = 1'b1;
    @(posedge i_clk);
    #1;
    do_reset();
    stream(20, 1'b1, 0, -1, 80);
    drain();

`ifdef DESCRAMBLER_BYPASS_EN
    // Bypass three words, then loopback must decode immediately.
    do_reset();
    i_bypass = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tx_raw(32'hA5A5A5A5);
      send_one(32'hA5A5A5A5, 32'hA5A5A5A5);
    end
    i_bypass = 1'b0;
    for (int k = 0; k < 5; k++) begin
      send_one(scramble(DW'(k + 100)), DW'(k + 100));
    end
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
